// File: rtl/game_sequencer.sv
// Game phase controller: menu, intro animation handshake, play, death/clear dwells and game over.
// Also owns the lives/level/win registers that feed the HUD and screen mux.
module game_sequencer #(
    parameter int LIVES       = 3,
    parameter int LEVELS      = 4,
    parameter int TICK_DIV    = 650000,
    parameter int DEATH_TICKS = 200,
    parameter int CLEAR_TICKS = 300,
    parameter int OVER_TICKS  = 500,
    localparam int LW   = $clog2(LIVES + 1),
    localparam int LVW  = (LEVELS > 1) ? $clog2(LEVELS) : 1,
    localparam int PW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1,
    localparam int MAXT = (DEATH_TICKS > CLEAR_TICKS)
                          ? ((DEATH_TICKS > OVER_TICKS) ? DEATH_TICKS : OVER_TICKS)
                          : ((CLEAR_TICKS > OVER_TICKS) ? CLEAR_TICKS : OVER_TICKS),
    localparam int TW   = (MAXT > 1) ? $clog2(MAXT) : 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start_btn,
    input  logic           anim_busy,
    input  logic           player_hit,
    input  logic           player_goal,
    output logic           anim_rst,
    output logic           anim_go,
    output logic           level_rst,
    output logic           play_en,
    output logic           freeze,
    output logic [LW-1:0]  lives,
    output logic [LVW-1:0] level,
    output logic [2:0]     screen,
    output logic           win
);

    typedef enum logic [2:0] {
        S_MENU, S_INTRO_ARM, S_INTRO, S_PLAY, S_DEATH, S_RESPAWN, S_CLEAR, S_OVER
    } state_t;

    state_t         state, state_nxt;
    logic           start_prev, start_rise;
    logic           armed;
    logic [PW-1:0]  presc;
    logic [TW-1:0]  tcnt;
    logic [TW-1:0]  dwell_last;
    logic           tick, dwell_done;

    // Resetting prev to 1 keeps a button held through reset from counting as a press.
    assign start_rise = start_btn & ~start_prev;
    assign tick       = (presc == PW'(TICK_DIV - 1));

    always_comb begin
        dwell_last = '0;
        case (state)
            S_DEATH: dwell_last = TW'(DEATH_TICKS - 1);
            S_CLEAR: dwell_last = TW'(CLEAR_TICKS - 1);
            S_OVER:  dwell_last = TW'(OVER_TICKS - 1);
            default: dwell_last = '0;
        endcase
    end

    assign dwell_done = tick && (tcnt == dwell_last);

    always_comb begin
        state_nxt = state;
        case (state)
            S_MENU:      if (start_rise) state_nxt = S_INTRO_ARM;
            S_INTRO_ARM: state_nxt = S_INTRO;
            S_INTRO:     if (armed && !anim_busy) state_nxt = S_PLAY;
            S_PLAY: begin
                if (player_hit)       state_nxt = S_DEATH;
                else if (player_goal) state_nxt = S_CLEAR;
            end
            S_DEATH:     if (dwell_done) state_nxt = (lives == '0) ? S_OVER : S_RESPAWN;
            S_RESPAWN:   state_nxt = S_PLAY;
            S_CLEAR:     if (dwell_done)
                             state_nxt = (level == LVW'(LEVELS - 1)) ? S_OVER : S_INTRO_ARM;
            S_OVER:      if (dwell_done) state_nxt = S_MENU;
            default:     state_nxt = S_MENU;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_MENU;
            start_prev <= 1'b1;
            armed      <= 1'b0;
            lives      <= LW'(LIVES);
            level      <= '0;
            win        <= 1'b0;
        end else begin
            state      <= state_nxt;
            start_prev <= start_btn;
            case (state)
                S_MENU: if (start_rise) begin
                    lives <= LW'(LIVES);
                    level <= '0;
                    win   <= 1'b0;
                end
                S_INTRO_ARM: armed <= 1'b0;
                S_INTRO:     if (anim_busy) armed <= 1'b1;
                S_PLAY:      if (player_hit && lives != '0) lives <= lives - LW'(1);
                S_DEATH:     if (dwell_done && lives == '0) win <= 1'b0;
                S_CLEAR: if (dwell_done) begin
                    if (level == LVW'(LEVELS - 1)) win <= 1'b1;
                    else                           level <= level + LVW'(1);
                end
                default: ;
            endcase
        end
    end

    // Timer restarts on every state change so each dwell is exactly N*TICK_DIV cycles.
    always_ff @(posedge clk) begin
        if (rst || state_nxt != state) begin
            presc <= '0;
            tcnt  <= '0;
        end else if (tick) begin
            presc <= '0;
            tcnt  <= tcnt + TW'(1);
        end else begin
            presc <= presc + PW'(1);
        end
    end

    always_comb begin
        anim_rst  = 1'b0;
        anim_go   = 1'b0;
        level_rst = 1'b0;
        play_en   = 1'b0;
        freeze    = 1'b0;
        screen    = 3'd0;
        case (state)
            S_MENU:      screen = 3'd0;
            S_INTRO_ARM: begin anim_rst = 1'b1; level_rst = 1'b1; screen = 3'd1; end
            S_INTRO:     begin anim_go = 1'b1; screen = 3'd1; end
            S_PLAY:      begin play_en = 1'b1; screen = 3'd2; end
            S_DEATH:     begin freeze = 1'b1; screen = 3'd3; end
            S_RESPAWN:   begin level_rst = 1'b1; screen = 3'd2; end
            S_CLEAR:     begin freeze = 1'b1; screen = 3'd4; end
            S_OVER:      screen = 3'd5;
            default:     screen = 3'd0;
        endcase
    end

endmodule

// File: tb/tb_game_sequencer.sv
// Directed bench for game_sequencer with short timing parameters; expected values hand-derived.
module tb_game_sequencer;

    logic       clk = 1'b0;
    logic       rst, start_btn, anim_busy, player_hit, player_goal;
    logic       anim_rst, anim_go, level_rst, play_en, freeze, win;
    logic [1:0] lives;
    logic [0:0] level;
    logic [2:0] screen;
    int         checks = 0;
    int         errors = 0;

    game_sequencer #(
        .LIVES(2), .LEVELS(2), .TICK_DIV(4),
        .DEATH_TICKS(3), .CLEAR_TICKS(2), .OVER_TICKS(2)
    ) dut (
        .clk(clk), .rst(rst), .start_btn(start_btn), .anim_busy(anim_busy),
        .player_hit(player_hit), .player_goal(player_goal),
        .anim_rst(anim_rst), .anim_go(anim_go), .level_rst(level_rst),
        .play_en(play_en), .freeze(freeze), .lives(lives), .level(level),
        .screen(screen), .win(win)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; start_btn = 1'b1; anim_busy = 1'b0;
        player_hit = 1'b0; player_goal = 1'b0;
        step(3);
        chk("rst_screen", screen, 0);
        chk("rst_lives", lives, 2);
        chk("rst_level", level, 0);
        chk("rst_win", win, 0);
        chk("rst_outs", {anim_rst, anim_go, level_rst, play_en, freeze}, 0);

        // 1: held button through reset is not a press
        rst = 1'b0;
        step(2);
        chk("held_no_edge", screen, 0);
        start_btn = 1'b0;
        step(1);
        chk("released_menu", screen, 0);
        start_btn = 1'b1;
        step(1);
        chk("arm_anim_rst", anim_rst, 1);
        chk("arm_level_rst", level_rst, 1);
        chk("arm_screen", screen, 1);
        chk("arm_lives", lives, 2);
        chk("arm_level", level, 0);
        step(1);
        chk("intro_anim_rst_once", anim_rst, 0);
        chk("intro_anim_go", anim_go, 1);
        start_btn = 1'b0;

        // 2: stale low busy ignored, exit only after the fall
        for (int i = 0; i < 3; i++) begin
            step(1);
            chk("stale_low_intro", screen, 1);
        end
        anim_busy = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step(1);
            chk("busy_intro", play_en, 0);
        end
        anim_busy = 1'b0;
        chk("fall_still_intro", screen, 1);
        step(1);
        chk("play_en_rise", play_en, 1);
        chk("play_screen", screen, 2);

        // 3: hit beats goal, DEATH dwell 12 cycles, RESPAWN one cycle
        player_hit = 1'b1; player_goal = 1'b1;
        step(1);
        player_hit = 1'b0; player_goal = 1'b0;
        chk("death_screen", screen, 3);
        chk("death_freeze", freeze, 1);
        chk("death_lives", lives, 1);
        step(11);
        chk("death_dwell_11", screen, 3);
        step(1);
        chk("respawn_screen", screen, 2);
        chk("respawn_level_rst", level_rst, 1);
        chk("respawn_play_en", play_en, 0);
        step(1);
        chk("replay_play_en", play_en, 1);
        chk("replay_level_rst", level_rst, 0);

        // 4: last life lost -> OVER win=0 -> MENU
        player_hit = 1'b1;
        step(1);
        player_hit = 1'b0;
        chk("death2_lives", lives, 0);
        step(11);
        chk("death2_dwell", screen, 3);
        step(1);
        chk("over_screen", screen, 5);
        chk("over_win0", win, 0);
        step(7);
        chk("over_dwell", screen, 5);
        step(1);
        chk("menu_after_over", screen, 0);

        // 5: level 0 clear replays intro, level 1 clear wins
        start_btn = 1'b1;
        step(1);
        start_btn = 1'b0;
        chk("start2_lives", lives, 2);
        chk("start2_screen", screen, 1);
        step(1);
        anim_busy = 1'b1; step(1);
        anim_busy = 1'b0; step(1);
        chk("play2", play_en, 1);
        player_goal = 1'b1;
        step(1);
        player_goal = 1'b0;
        chk("clear_screen", screen, 4);
        chk("clear_freeze", freeze, 1);
        step(7);
        chk("clear_dwell", screen, 4);
        step(1);
        chk("lvl1_anim_rst", anim_rst, 1);
        chk("lvl1_level", level, 1);
        step(1);
        anim_busy = 1'b1; step(1);
        anim_busy = 1'b0; step(1);
        chk("play_lvl1", play_en, 1);
        player_goal = 1'b1;
        step(1);
        player_goal = 1'b0;
        step(8);
        chk("win_over_screen", screen, 5);
        chk("win_flag", win, 1);
        chk("win_level", level, 1);
        step(8);
        chk("win_menu", screen, 0);
        chk("win_held_menu", win, 1);

        // 6: reset mid-DEATH
        start_btn = 1'b1;
        step(1);
        start_btn = 1'b0;
        chk("start3_win_clr", win, 0);
        step(1);
        anim_busy = 1'b1; step(1);
        anim_busy = 1'b0; step(1);
        player_hit = 1'b1;
        step(1);
        player_hit = 1'b0;
        chk("death3_lives", lives, 1);
        step(5);
        rst = 1'b1;
        step(1);
        chk("midrst_screen", screen, 0);
        chk("midrst_lives", lives, 2);
        chk("midrst_level", level, 0);
        chk("midrst_freeze", freeze, 0);
        chk("midrst_anim_rst", anim_rst, 0);
        rst = 1'b0;
        step(2);
        chk("post_rst_menu", screen, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
